// File: rtl/branch_resolve_queue_pkg.sv
// bp_pkg: types and constants shared by the branch predictor and the resolve queue.
package bp_pkg;
  localparam int PC_W_DEF = 32;
  localparam int PC_INC = 4;
  localparam logic [1:0] ST_SNT = 2'd0;
  localparam logic [1:0] ST_WNT = 2'd1;
  localparam logic [1:0] ST_WT = 2'd2;
  localparam logic [1:0] ST_ST = 2'd3;
  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic taken;
    logic [PC_W_DEF-1:0] target;
  } bp_entry_t;
endpackage

// File: rtl/branch_resolve_queue_if.sv
// branch_resolve_queue_if: fetch push, execute resolve, training and redirect signals.
interface branch_resolve_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W = 32,
  parameter int CNT_W = 16
);
  logic i_pred_valid;
  logic [PC_W-1:0] i_pred_pc;
  logic i_pred_taken;
  logic [PC_W-1:0] i_pred_target;
  logic o_pred_ready;
  logic i_res_valid;
  logic i_res_taken;
  logic [PC_W-1:0] i_res_target;
  logic o_res_ready;
  logic o_train_valid;
  logic o_train_taken;
  logic [PC_W-1:0] o_train_pc;
  logic o_mispredict;
  logic [PC_W-1:0] o_redirect_pc;
  logic [$clog2(DEPTH):0] o_count;
  logic [CNT_W-1:0] o_branch_cnt;
  logic [CNT_W-1:0] o_mispred_cnt;
  modport master (
    output i_pred_valid, i_pred_pc, i_pred_taken, i_pred_target, i_res_valid, i_res_taken, i_res_target,
    input o_pred_ready, o_res_ready, o_train_valid, o_train_taken, o_train_pc, o_mispredict,
    o_redirect_pc, o_count, o_branch_cnt, o_mispred_cnt
  );
  modport slave (
    input i_pred_valid, i_pred_pc, i_pred_taken, i_pred_target, i_res_valid, i_res_taken, i_res_target,
    output o_pred_ready, o_res_ready, o_train_valid, o_train_taken, o_train_pc, o_mispredict,
    o_redirect_pc, o_count, o_branch_cnt, o_mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_queue_fifo.sv
// bp_fifo: circular buffer with push/pop, whole-queue flush and occupancy count.
module bp_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: resolves queued branch predictions in order, trains the predictor and redirects on mispredict.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W = 32,
  parameter int CNT_W = 16
) (
  input logic i_clk,
  input logic i_rst,
  branch_resolve_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic taken;
    logic [PC_W-1:0] target;
  } entry_t;
  entry_t din, head;
  logic [CW-1:0] count;
  logic pred_ready, res_ready, push, pop, mis;
  logic [PC_W-1:0] redirect;
  assign pred_ready = count < CW'(DEPTH);
  assign res_ready = count != '0;
  assign push = bus.i_pred_valid && pred_ready;
  assign pop = bus.i_res_valid && res_ready;
  assign din = '{pc: bus.i_pred_pc, taken: bus.i_pred_taken, target: bus.i_pred_target};
  assign mis = head.taken != bus.i_res_taken || (head.taken && head.target != bus.i_res_target);
  assign redirect = bus.i_res_taken ? bus.i_res_target : head.pc + PC_W'(PC_INC);
  assign bus.o_pred_ready = pred_ready;
  assign bus.o_res_ready = res_ready;
  assign bus.o_count = count;
  // a mispredicting pop empties the queue and drops any wrong-path push in the same cycle
  bp_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
    .clk(i_clk),
    .rst(i_rst),
    .push(push),
    .pop(pop),
    .flush(pop && mis),
    .din(din),
    .dout(head),
    .count(count)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_train_valid <= 1'b0;
      bus.o_train_taken <= 1'b0;
      bus.o_train_pc <= '0;
      bus.o_mispredict <= 1'b0;
      bus.o_redirect_pc <= '0;
      bus.o_branch_cnt <= '0;
      bus.o_mispred_cnt <= '0;
    end else begin
      bus.o_train_valid <= pop;
      bus.o_mispredict <= pop && mis;
      if (pop) begin
        bus.o_train_taken <= bus.i_res_taken;
        bus.o_train_pc <= head.pc;
        if (!(&bus.o_branch_cnt)) bus.o_branch_cnt <= bus.o_branch_cnt + 1'b1;
      end
      if (pop && mis) begin
        bus.o_redirect_pc <= redirect;
        if (!(&bus.o_mispred_cnt)) bus.o_mispred_cnt <= bus.o_mispred_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: table vectors, corner sequences and random traffic against a queue model.
module tb_branch_resolve_queue;
  localparam int DEPTH = 4;
  localparam int CNT_MAX = 15;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  branch_resolve_queue_if #(.DEPTH(DEPTH), .PC_W(32), .CNT_W(4)) bus ();
  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(32), .CNT_W(4)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );
  typedef struct {
    logic [31:0] pc;
    logic t;
    logic [31:0] tg;
  } ent_t;
  ent_t mq[$];
  logic e_tv, e_tt, e_mis;
  logic [31:0] e_tpc, e_rpc;
  int e_bc, e_mc;
  typedef struct {
    logic pv;
    logic [31:0] ppc;
    logic pt;
    logic [31:0] ptg;
    logic rv;
    logic rt;
    logic [31:0] rtg;
    logic x_tv, x_tt, x_mis;
    logic [31:0] x_rpc;
    int x_cnt, x_bc, x_mc;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic pv, input logic [31:0] ppc, input logic pt,
                      input logic [31:0] ptg, input logic rv, input logic rt, input logic [31:0] rtg);
    bit pok, rok, m;
    ent_t h;
    rst = r;
    bus.i_pred_valid = pv;
    bus.i_pred_pc = ppc;
    bus.i_pred_taken = pt;
    bus.i_pred_target = ptg;
    bus.i_res_valid = rv;
    bus.i_res_taken = rt;
    bus.i_res_target = rtg;
    if (r) begin
      mq.delete();
      {e_tv, e_tt, e_mis, e_tpc, e_rpc} = '0;
      e_bc = 0;
      e_mc = 0;
    end else begin
      pok = pv && mq.size() < DEPTH;
      rok = rv && mq.size() > 0;
      e_tv = rok;
      e_mis = 1'b0;
      if (rok) begin
        h = mq.pop_front();
        m = (h.t != rt) || (rt && h.tg != rtg);
        e_tt = rt;
        e_tpc = h.pc;
        e_bc = (e_bc == CNT_MAX) ? CNT_MAX : e_bc + 1;
        if (m) begin
          e_mis = 1'b1;
          e_rpc = rt ? rtg : h.pc + 32'd4;
          e_mc = (e_mc == CNT_MAX) ? CNT_MAX : e_mc + 1;
          mq.delete();
          pok = 1'b0;
        end
      end
      if (pok) mq.push_back('{pc: ppc, t: pt, tg: ptg});
    end
    @(posedge clk);
    #1;
    chk("count", 32'(bus.o_count), 32'(mq.size()));
    chk("pred_ready", 32'(bus.o_pred_ready), 32'(mq.size() < DEPTH));
    chk("res_ready", 32'(bus.o_res_ready), 32'(mq.size() > 0));
    chk("train_valid", 32'(bus.o_train_valid), 32'(e_tv));
    chk("train_taken", 32'(bus.o_train_taken), 32'(e_tt));
    chk("train_pc", bus.o_train_pc, e_tpc);
    chk("mispredict", 32'(bus.o_mispredict), 32'(e_mis));
    chk("redirect_pc", bus.o_redirect_pc, e_rpc);
    chk("branch_cnt", 32'(bus.o_branch_cnt), 32'(e_bc));
    chk("mispred_cnt", 32'(bus.o_mispred_cnt), 32'(e_mc));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    vt[0]  = '{1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0};
    vt[1]  = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 32'h0, 0, 1, 0};
    vt[2]  = '{1, 32'h200, 1, 32'h300, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0};
    vt[3]  = '{0, 0, 0, 0, 1, 1, 32'h340, 1, 1, 1, 32'h340, 0, 2, 1};
    vt[4]  = '{1, 32'h400, 1, 32'h500, 0, 0, 0, 0, 1, 0, 32'h340, 1, 2, 1};
    vt[5]  = '{1, 32'h410, 0, 0, 0, 0, 0, 0, 1, 0, 32'h340, 2, 2, 1};
    vt[6]  = '{1, 32'h420, 0, 0, 0, 0, 0, 0, 1, 0, 32'h340, 3, 2, 1};
    vt[7]  = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 32'h404, 0, 3, 2};
    vt[8]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h404, 0, 3, 2};
    vt[9]  = '{1, 32'h500, 0, 0, 1, 0, 0, 0, 0, 0, 32'h404, 1, 3, 2};
    vt[10] = '{1, 32'h504, 0, 0, 1, 0, 0, 1, 0, 0, 32'h404, 1, 4, 2};
    vt[11] = '{1, 32'h508, 1, 32'h600, 1, 1, 32'h700, 1, 1, 1, 32'h700, 0, 5, 3};
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pred_ready", 32'(bus.o_pred_ready), 32'd1);
    chk("rst_res_ready", 32'(bus.o_res_ready), 32'd0);
    foreach (vt[i]) begin
      step(0, vt[i].pv, vt[i].ppc, vt[i].pt, vt[i].ptg, vt[i].rv, vt[i].rt, vt[i].rtg);
      chk($sformatf("v%0d_tv", i), 32'(bus.o_train_valid), 32'(vt[i].x_tv));
      if (vt[i].x_tv) chk($sformatf("v%0d_tt", i), 32'(bus.o_train_taken), 32'(vt[i].x_tt));
      chk($sformatf("v%0d_mis", i), 32'(bus.o_mispredict), 32'(vt[i].x_mis));
      chk($sformatf("v%0d_rpc", i), bus.o_redirect_pc, vt[i].x_rpc);
      chk($sformatf("v%0d_cnt", i), 32'(bus.o_count), 32'(vt[i].x_cnt));
      chk($sformatf("v%0d_bc", i), 32'(bus.o_branch_cnt), 32'(vt[i].x_bc));
      chk($sformatf("v%0d_mc", i), 32'(bus.o_mispred_cnt), 32'(vt[i].x_mc));
    end
    for (int i = 0; i < DEPTH; i++) step(0, 1, 32'h1000 + 32'(i * 4), 0, 0, 0, 0, 0);
    chk("full_count", 32'(bus.o_count), 32'd4);
    chk("full_ready", 32'(bus.o_pred_ready), 32'd0);
    step(0, 1, 32'h1100, 0, 0, 0, 0, 0);
    chk("full_push_held", 32'(bus.o_count), 32'd4);
    step(0, 1, 32'h1104, 0, 0, 1, 0, 0);
    chk("full_pop_no_bypass", 32'(bus.o_count), 32'd3);
    chk("ready_after_pop", 32'(bus.o_pred_ready), 32'd1);
    chk("pop_pc_first", bus.o_train_pc, 32'h1000);
    for (int i = 0; i < 8; i++) step(0, 1, 32'h2000 + 32'(i * 4), 0, 0, 1, 0, 0);
    chk("wrap_pc_order", bus.o_train_pc, 32'h2010);
    chk("wrap_count", 32'(bus.o_count), 32'd3);
    idle();
    step(1, 0, 0, 0, 0, 1, 1, 32'h9);
    chk("midrst_count", 32'(bus.o_count), 32'd0);
    chk("midrst_bc", 32'(bus.o_branch_cnt), 32'd0);
    chk("midrst_strobe", 32'({bus.o_train_valid, bus.o_mispredict}), 32'd0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 32'h3000 + 32'(i * 4), 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0, 0);
      if (i == 14) chk("sat_reach", 32'(bus.o_branch_cnt), 32'd15);
    end
    chk("sat_hold", 32'(bus.o_branch_cnt), 32'd15);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 49) == 0, 1'($urandom), 32'h100 + 32'($urandom_range(0, 15) * 4),
           1'($urandom), 32'($urandom_range(0, 3) * 16), $urandom_range(0, 2) != 0, 1'($urandom),
           32'($urandom_range(0, 3) * 16));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
